// File: rtl/spi_serf_if.sv
// SPI link and host-side handshake for spi_serf, bundled so the serf and its
// users (monarch model, board-debug glue) share one set of port names.
interface spi_serf_if #(
  parameter int DATA_W = 16
);

  logic              SS_n;
  logic              SCLK;
  logic              MOSI;
  logic              MISO;
  logic              wrt;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              rdy;
  logic              frm_err;

  // The serf side: SPI pins in, MISO out, host word load in, status out.
  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO,
    input  wrt,
    input  tx_data,
    output rx_data,
    output rdy,
    output frm_err
  );

  // The monarch/host side drives everything the serf samples.
  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO,
    output wrt,
    output tx_data,
    input  rx_data,
    input  rdy,
    input  frm_err
  );

endinterface

// File: rtl/spi_serf.sv
// SPI responder (serf) for the 16-bit sensor-link monarch. SCLK idles high,
// the monarch launches on SCLK fall and captures on SCLK rise, MSB first.
// All SPI pins are asynchronous to clk and pass through 3-flop synchronizers;
// only SCLK rises and SS_n edges cause action, SCLK falls are ignored.
module spi_serf #(
  parameter int DATA_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_serf_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              ss_ff1, ss_ff2, ss_ff3;
  logic              sclk_ff1, sclk_ff2, sclk_ff3;
  logic              mosi_ff1, mosi_ff2, mosi_ff3;

  logic              sclk_rise;
  logic              ss_fall;
  logic              ss_rise;

  logic [DATA_W-1:0] shft_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cnt_upd;
  logic              shift_en;
  logic              over_len;
  logic              frame_ok;
  logic              rdy_q;
  logic              frm_err_q;

  // Synchronize the asynchronous SPI pins; the third stage feeds edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_ff1   <= 1'b1;
      ss_ff2   <= 1'b1;
      ss_ff3   <= 1'b1;
      sclk_ff1 <= 1'b1;
      sclk_ff2 <= 1'b1;
      sclk_ff3 <= 1'b1;
      mosi_ff1 <= 1'b0;
      mosi_ff2 <= 1'b0;
      mosi_ff3 <= 1'b0;
    end else begin
      ss_ff1   <= bus.SS_n;
      ss_ff2   <= ss_ff1;
      ss_ff3   <= ss_ff2;
      sclk_ff1 <= bus.SCLK;
      sclk_ff2 <= sclk_ff1;
      sclk_ff3 <= sclk_ff2;
      mosi_ff1 <= bus.MOSI;
      mosi_ff2 <= mosi_ff1;
      mosi_ff3 <= mosi_ff2;
    end
  end

  assign sclk_rise = sclk_ff2 & ~sclk_ff3;
  assign ss_fall   = ~ss_ff2 & ss_ff3;
  assign ss_rise   = ss_ff2 & ~ss_ff3;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the shift/end-of-frame decisions; a rise coinciding with
  // SS_n going high shifts first, so the frame check looks at the updated count.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    over_len  = 1'b0;
    cnt_upd   = bit_cnt;
    frame_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = sclk_rise && (bit_cnt < FULL_CNT);
        over_len = sclk_rise && (bit_cnt == FULL_CNT);
        if (shift_en) begin
          cnt_upd = bit_cnt + CNT_W'(1);
        end
        if (ss_rise) begin
          state_nxt = IDLE;
          frame_ok  = (cnt_upd == FULL_CNT) && !frm_err_q && !over_len;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and frame status; host loads only land in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft_reg  <= '0;
      bit_cnt   <= '0;
      rdy_q     <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      bit_cnt <= cnt_upd;
      if (state == IDLE) begin
        if (bus.wrt) begin
          shft_reg <= bus.tx_data;
          rdy_q    <= 1'b0;
        end
        if (ss_fall) begin
          bit_cnt   <= '0;
          rdy_q     <= 1'b0;
          frm_err_q <= 1'b0;
        end
      end else begin
        if (shift_en) begin
          shft_reg <= {shft_reg[DATA_W-2:0], mosi_ff3};
        end
        if (over_len) begin
          frm_err_q <= 1'b1;
        end
        if (ss_rise) begin
          if (frame_ok) begin
            rdy_q <= 1'b1;
          end else begin
            frm_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.MISO    = ss_ff2 ? 1'b1 : shft_reg[DATA_W-1];
  assign bus.rx_data = shft_reg;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a simple monarch model clocks frames with an
// 8-clk SCLK half-period and collects the serf's MISO response.
module tb_spi_serf;

  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  logic [15:0] resp;

  always #5 clk = ~clk;

  spi_serf_if #(.DATA_W(DATA_W)) bus ();

  spi_serf #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host-side word load while the serf is idle.
  task automatic load_word(input logic [15:0] word);
    bus.tx_data = word;
    bus.wrt     = 1'b1;
    wait_clk(1);
    bus.wrt     = 1'b0;
  endtask

  // One SS_n-low frame of nbits SCLK rises. Optionally a host load at bit
  // wrt_bit and a reset pulse at bit rst_bit (-1 disables either).
  task automatic applyStimulus(input logic [15:0] word, input int nbits,
                               input int wrt_bit, input logic [15:0] wrt_word,
                               input int rst_bit, output logic [15:0] rd);
    logic [15:0] w;
    w  = word;
    rd = '0;
    bus.SS_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) begin
        rst_n = 1'b0;
        wait_clk(2);
        checkOutput("rst_mid_rdy",     {15'b0, bus.rdy},     16'h0000);
        checkOutput("rst_mid_frm_err", {15'b0, bus.frm_err}, 16'h0000);
        checkOutput("rst_mid_rx_data", bus.rx_data,          16'h0000);
        checkOutput("rst_mid_miso",    {15'b0, bus.MISO},    16'h0001);
        rst_n = 1'b1;
        wait_clk(4);
      end
      if (i == wrt_bit) begin
        load_word(wrt_word);
      end
      bus.SCLK = 1'b0;
      bus.MOSI = (i < 16) ? w[15 - i] : 1'b0;
      wait_clk(8);
      if (i < 16) begin
        rd = {rd[14:0], bus.MISO};
      end
      bus.SCLK = 1'b1;
      wait_clk(8);
    end
    bus.SS_n = 1'b1;
    wait_clk(8);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst_n       = 1'b0;
    bus.SS_n    = 1'b1;
    bus.SCLK    = 1'b1;
    bus.MOSI    = 1'b0;
    bus.wrt     = 1'b0;
    bus.tx_data = '0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    checkOutput("reset_rdy",     {15'b0, bus.rdy},     16'h0000);
    checkOutput("reset_frm_err", {15'b0, bus.frm_err}, 16'h0000);
    checkOutput("reset_rx_data", bus.rx_data,          16'h0000);
    checkOutput("reset_miso",    {15'b0, bus.MISO},    16'h0001);

    $display("[TB] basic frame");
    load_word(16'hA5C3);
    applyStimulus(16'h8C00, 16, -1, 16'h0000, -1, resp);
    checkOutput("t1_rx_data", bus.rx_data,          16'h8C00);
    checkOutput("t1_rdy",     {15'b0, bus.rdy},     16'h0001);
    checkOutput("t1_frm_err", {15'b0, bus.frm_err}, 16'h0000);
    checkOutput("t1_resp",    resp,                 16'hA5C3);

    $display("[TB] back-to-back frames");
    applyStimulus(16'h1234, 16, -1, 16'h0000, -1, resp);
    checkOutput("t2a_resp",    resp,             16'h8C00);
    checkOutput("t2a_rx_data", bus.rx_data,      16'h1234);
    checkOutput("t2a_rdy",     {15'b0, bus.rdy}, 16'h0001);
    load_word(16'h0F0F);
    wait_clk(1);
    checkOutput("t2_wrt_rdy",  {15'b0, bus.rdy}, 16'h0000);
    checkOutput("t2_wrt_rx",   bus.rx_data,      16'h0F0F);
    applyStimulus(16'hFFFF, 16, -1, 16'h0000, -1, resp);
    checkOutput("t2b_resp",    resp,             16'h0F0F);
    checkOutput("t2b_rx_data", bus.rx_data,      16'hFFFF);
    checkOutput("t2b_rdy",     {15'b0, bus.rdy}, 16'h0001);

    $display("[TB] short frame then recovery");
    applyStimulus(16'hA500, 8, -1, 16'h0000, -1, resp);
    checkOutput("t3_short_rdy",     {15'b0, bus.rdy},     16'h0000);
    checkOutput("t3_short_frm_err", {15'b0, bus.frm_err}, 16'h0001);
    applyStimulus(16'h5555, 16, -1, 16'h0000, -1, resp);
    checkOutput("t3_rx_data", bus.rx_data,          16'h5555);
    checkOutput("t3_rdy",     {15'b0, bus.rdy},     16'h0001);
    checkOutput("t3_frm_err", {15'b0, bus.frm_err}, 16'h0000);

    $display("[TB] over-length frame");
    applyStimulus(16'h9A7E, 17, -1, 16'h0000, -1, resp);
    checkOutput("t4_rx_data", bus.rx_data,          16'h9A7E);
    checkOutput("t4_rdy",     {15'b0, bus.rdy},     16'h0000);
    checkOutput("t4_frm_err", {15'b0, bus.frm_err}, 16'h0001);

    $display("[TB] host load during frame");
    load_word(16'h3C96);
    applyStimulus(16'h6B21, 16, 5, 16'hDEAD, -1, resp);
    checkOutput("t5_resp",    resp,                 16'h3C96);
    checkOutput("t5_rx_data", bus.rx_data,          16'h6B21);
    checkOutput("t5_rdy",     {15'b0, bus.rdy},     16'h0001);
    checkOutput("t5_frm_err", {15'b0, bus.frm_err}, 16'h0000);

    $display("[TB] reset mid-frame");
    applyStimulus(16'h7E81, 16, -1, 16'h0000, 6, resp);
    checkOutput("t6_part_rdy",     {15'b0, bus.rdy},     16'h0000);
    checkOutput("t6_part_frm_err", {15'b0, bus.frm_err}, 16'h0001);
    applyStimulus(16'hC3C3, 16, -1, 16'h0000, -1, resp);
    checkOutput("t6_rx_data", bus.rx_data,          16'hC3C3);
    checkOutput("t6_rdy",     {15'b0, bus.rdy},     16'h0001);
    checkOutput("t6_frm_err", {15'b0, bus.frm_err}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
